mult_div_unit: RTL



---
 rtl/mult_div_unit_pkg.sv | 32 +++
 rtl/mult_div_unit_if.sv | 31 +++
 rtl/mult_div_unit_md_step.sv | 52 +++++
 rtl/mult_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the HI/LO multiply/divide unit: default datapath
// widths (also used by the register file and ALU), op encodings and the FSM
// state type.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } md_state_e;

    // Ops 000..011 are the iterative mult/div family.
    function automatic logic md_is_iter_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Issue/result bundle between pipeline control and the mult/div unit.
//   start, op, flush, Rs, Rt : issue side (driven by master)
//   Hi, Lo, busy, done       : result/status side (driven by slave)
// -----------------------------------------------------------------------------
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] Rs;
    logic [WIDTH-1:0] Rt;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, flush, Rs, Rt,
        input  Hi, Lo, busy, done
    );

    modport slave (
        input  start, op, flush, Rs, Rt,
        output Hi, Lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit_md_step.sv
// -----------------------------------------------------------------------------
// md_step
// Combinational single iteration of the mult/div datapath.
//   i_is_div : 0 = shift-add multiply, 1 = restoring divide
//   i_acc    : upper half (partial product / partial remainder)
//   i_sreg   : lower half (multiplier bits / dividend-then-quotient bits)
//   i_opnd   : multiplicand (mul) or divisor (div), unsigned magnitude
//   o_acc, o_sreg : next-iteration halves
//   o_qbit   : quotient bit produced this iteration (0 for multiply)
// -----------------------------------------------------------------------------
module md_step
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_sreg,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_sreg,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        // Multiply: add multiplicand if the current multiplier LSB is set,
        // then shift {carry, acc, sreg} right by one.
        w_sum  = {1'b0, i_acc} + {1'b0, (i_sreg[0] ? i_opnd : {WIDTH{1'b0}})};
        // Divide: shift {acc, sreg} left by one, trial-subtract the divisor.
        w_rem  = {i_acc, i_sreg[WIDTH-1]};
        w_ge   = (w_rem >= {1'b0, i_opnd});
        // Only used when w_ge, where the true difference is < divisor and so
        // fits in WIDTH bits; the dropped top bit is always zero.
        w_diff = w_rem[WIDTH-1:0] - i_opnd;

        if (i_is_div) begin
            o_qbit = w_ge;
            o_acc  = w_ge ? w_diff : w_rem[WIDTH-1:0];
            o_sreg = {i_sreg[WIDTH-2:0], w_ge};
        end else begin
            o_qbit = 1'b0;
            o_acc  = w_sum[WIDTH:1];
            o_sreg = {w_sum[0], i_sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative HI/LO multiply/divide unit. MULT/MULTU/DIV/DIVU run one bit per
// cycle (32 iterations + one sign-fix cycle); MTHI/MTLO write in one cycle.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : slave side of mult_div_unit_if (start/op/flush/Rs/Rt in,
//         Hi/Lo/busy/done out)
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);

    md_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [WIDTH-1:0] r_acc, w_acc_d;
    logic [WIDTH-1:0] r_sreg, w_sreg_d;
    logic [WIDTH-1:0] r_opnd, w_opnd_d;
    logic [WIDTH-1:0] r_rs_raw, w_rs_raw_d;
    logic             r_is_div, w_is_div_d;
    logic             r_neg_res, w_neg_res_d;
    logic             r_neg_rem, w_neg_rem_d;
    logic             r_div0, w_div0_d;
    logic [WIDTH-1:0] r_hi, w_hi_d;
    logic [WIDTH-1:0] r_lo, w_lo_d;
    logic             r_done, w_done_d;

    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_sreg;
    logic               w_step_qbit;
    logic               w_op_signed;
    logic               w_op_div;
    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    md_step #(
        .WIDTH (WIDTH)
    ) u_md_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_sreg   (r_sreg),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc),
        .o_sreg   (w_step_sreg),
        .o_qbit   (w_step_qbit)
    );

    // Even op codes in the iterative family are the signed variants.
    assign w_op_signed = ~bus.op[0];
    assign w_op_div    = bus.op[1];
    assign w_abs_rs    = (w_op_signed && bus.Rs[WIDTH-1]) ? -bus.Rs : bus.Rs;
    assign w_abs_rt    = (w_op_signed && bus.Rt[WIDTH-1]) ? -bus.Rt : bus.Rt;

    // Sign correction applied in the FIX cycle. Negating 0x80000000 yields
    // itself, which gives the wrap-around result for INT_MIN / -1.
    assign w_prod     = {r_acc, r_sreg};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -r_sreg : r_sreg;
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_acc_d     = r_acc;
        w_sreg_d    = r_sreg;
        w_opnd_d    = r_opnd;
        w_rs_raw_d  = r_rs_raw;
        w_is_div_d  = r_is_div;
        w_neg_res_d = r_neg_res;
        w_neg_rem_d = r_neg_rem;
        w_div0_d    = r_div0;
        w_hi_d      = r_hi;
        w_lo_d      = r_lo;
        w_done_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (md_is_iter_op(bus.op)) begin
                        w_is_div_d  = w_op_div;
                        w_rs_raw_d  = bus.Rs;
                        w_neg_res_d = w_op_signed & (bus.Rs[WIDTH-1] ^ bus.Rt[WIDTH-1]);
                        w_neg_rem_d = w_op_signed & w_op_div & bus.Rs[WIDTH-1];
                        w_div0_d    = w_op_div & (bus.Rt == '0);
                        w_acc_d     = '0;
                        w_cnt_d     = '0;
                        // Multiply keeps the multiplier in sreg; divide shifts
                        // the dividend out of sreg while quotient bits enter.
                        w_sreg_d    = w_op_div ? w_abs_rs : w_abs_rt;
                        w_opnd_d    = w_op_div ? w_abs_rt : w_abs_rs;
                        w_state_d   = StRun;
                    end else if (bus.op == OP_MTHI) begin
                        w_hi_d = bus.Rs;
                    end else if (bus.op == OP_MTLO) begin
                        w_lo_d = bus.Rs;
                    end
                end
            end
            StRun: begin
                if (bus.flush) begin
                    w_state_d = StIdle;
                end else begin
                    w_acc_d  = w_step_acc;
                    w_sreg_d = w_step_sreg;
                    w_cnt_d  = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_d = StFix;
                    end
                end
            end
            StFix: begin
                w_state_d = StIdle;
                if (!bus.flush) begin
                    w_done_d = 1'b1;
                    if (!r_is_div) begin
                        w_hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                        w_lo_d = w_prod_fix[WIDTH-1:0];
                    end else if (r_div0) begin
                        w_hi_d = r_rs_raw;
                        w_lo_d = '1;
                    end else begin
                        w_hi_d = w_rem_fix;
                        w_lo_d = w_quo_fix;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_sreg    <= '0;
            r_opnd    <= '0;
            r_rs_raw  <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_acc     <= w_acc_d;
            r_sreg    <= w_sreg_d;
            r_opnd    <= w_opnd_d;
            r_rs_raw  <= w_rs_raw_d;
            r_is_div  <= w_is_div_d;
            r_neg_res <= w_neg_res_d;
            r_neg_rem <= w_neg_rem_d;
            r_div0    <= w_div0_d;
            r_hi      <= w_hi_d;
            r_lo      <= w_lo_d;
            r_done    <= w_done_d;
        end
    end

    assign bus.Hi   = r_hi;
    assign bus.Lo   = r_lo;
    assign bus.busy = (r_state != StIdle);
    assign bus.done = r_done;

endmodule
